// File: rtl/mem_responder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_pkg                                                          |
// | Shared state/op encodings and default widths for mem_responder.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mem_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_WAIT_CYC = 2;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_responder_if                                                 |
// | Request/response bus between the control FSM and mem_responder.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WData;
    logic [DATA_W-1:0] RData;
    logic              MemReady;
    logic              Busy;
    logic              ReqErr;

    modport master (
        output MemRead, MemWrite, Addr, WData,
        input  RData, MemReady, Busy, ReqErr
    );

    modport slave (
        input  MemRead, MemWrite, Addr, WData,
        output RData, MemReady, Busy, ReqErr
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder_sram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_sram                                                         |
// | Single-port synchronous RAM, one-cycle registered read.          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_sram
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  wire logic              clock,
    input  wire logic              reset_n,
    input  wire logic              en,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] addr,
    input  wire logic [DATA_W-1:0] wdata,
    output logic      [DATA_W-1:0] rdata
);
    localparam int c_depth = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_depth];
    logic [DATA_W-1:0] r_rdata;

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clock) begin
        if (en && we) begin
            r_mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (en && !we) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_responder                                                    |
// | Wait-state memory responder: IDLE -> WAIT -> RESP handshake.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int WAIT_CYC = DEF_WAIT_CYC
) (
    input wire logic         clock,
    input wire logic         reset_n,
    mem_responder_if.slave   bus
);
    generate
        if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_wait_cyc
            $error("mem_responder: WAIT_CYC must be within 0..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_wait_load = (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;
    localparam logic             c_no_wait   = (WAIT_CYC == 0);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_op;
    logic              r_ready;
    logic              r_busy;
    logic              r_err;

    logic              w_req;
    logic              w_in_idle;
    logic              w_ram_en;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_rdata;

    assign w_req     = bus.MemRead | bus.MemWrite;
    assign w_in_idle = (r_state == IDLE);

    // RAM fires only on the edge that enters RESP; with no wait states that
    // edge is the acceptance edge, so the live bus inputs feed the RAM.
    assign w_ram_en    = reset_n & ((w_in_idle & w_req & c_no_wait) |
                                    ((r_state == WAIT) & (r_cnt == '0)));
    assign w_ram_we    = w_in_idle ? bus.MemWrite : (r_op == OP_WR);
    assign w_ram_addr  = w_in_idle ? bus.Addr     : r_addr;
    assign w_ram_wdata = w_in_idle ? bus.WData    : r_wdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= OP_RD;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr  <= bus.Addr;
                        r_wdata <= bus.WData;
                        r_op    <= bus.MemWrite ? OP_WR : OP_RD;
                        r_err   <= bus.MemRead & bus.MemWrite;
                        r_busy  <= 1'b1;
                        if (c_no_wait) begin
                            r_state <= RESP;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= c_wait_load;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    mem_sram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (w_ram_en),
        .we      (w_ram_we),
        .addr    (w_ram_addr),
        .wdata   (w_ram_wdata),
        .rdata   (w_rdata)
    );

    assign bus.RData    = w_rdata;
    assign bus.MemReady = r_ready;
    assign bus.Busy     = r_busy;
    assign bus.ReqErr   = r_err;

endmodule
`default_nettype wire
